// File: rtl/bcd_disp_pkg.sv
// Shared constants for the 3-digit multiplexed 7-segment scanner.
// Glyphs are active-high, ordered {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } slot_state_e;

    localparam logic [1:0] IDX_UNITS    = 2'd0;
    localparam logic [1:0] IDX_TENS     = 2'd1;
    localparam logic [1:0] IDX_HUNDREDS = 2'd2;

    // Any non-BCD code renders as a dash; this one is used to force it.
    localparam logic [3:0] DIGIT_DASH = 4'hF;

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-high 7-segment glyph; codes above 9 render as a dash.
module seg7_decode
    import bcd_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_DASH;
        if (blank) begin
            glyph = SEG_OFF;
        end else begin
            case (digit)
                4'd0:    glyph = SEG_0;
                4'd1:    glyph = SEG_1;
                4'd2:    glyph = SEG_2;
                4'd3:    glyph = SEG_3;
                4'd4:    glyph = SEG_4;
                4'd5:    glyph = SEG_5;
                4'd6:    glyph = SEG_6;
                4'd7:    glyph = SEG_7;
                4'd8:    glyph = SEG_8;
                4'd9:    glyph = SEG_9;
                default: glyph = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_scan.sv
// 3-digit multiplexed common-anode display driver: shadow/display double buffering,
// per-slot anti-ghost blanking and leading-zero suppression; all outputs registered.
module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int unsigned SLOT_CYCLES    = 1000,
    parameter int unsigned BLANK_CYCLES   = 16,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    parameter bit          LZ_BLANK       = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] units,
    input  logic [3:0] tens,
    input  logic [1:0] hundreds,
    output logic [6:0] seg,
    output logic       dp,
    output logic [2:0] an,
    output logic       frame_tick
);

    localparam int unsigned      CNT_W    = $clog2(SLOT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ON   = CNT_W'(BLANK_CYCLES);
    localparam logic [6:0]       SEG_RST  = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic [2:0]       AN_RST   = AN_ACTIVE_LOW ? 3'b111 : 3'b000;
    localparam logic             DP_RST   = SEG_ACTIVE_LOW;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    slot_state_e      state_q, state_d;

    logic [3:0] shadow_u_q, shadow_u_d, shadow_t_q, shadow_t_d;
    logic [1:0] shadow_h_q, shadow_h_d;
    logic       pending_q, pending_d;
    logic [3:0] disp_u_q, disp_u_d, disp_t_q, disp_t_d;
    logic [1:0] disp_h_q, disp_h_d;

    logic [6:0] seg_q, seg_d;
    logic [2:0] an_q, an_d;
    logic       dp_q, dp_d;
    logic       tick_q, tick_d;

    logic       cnt_wrap;
    logic       boundary;
    logic [3:0] dec_digit;
    logic       dec_blank;
    logic [6:0] glyph;
    logic [2:0] an_onehot;

    // Slot counter, digit index and the BLANK/ON slot FSM.
    always_comb begin
        cnt_wrap = (cnt_q == CNT_LAST);
        boundary = cnt_wrap && (idx_q == IDX_HUNDREDS);
        cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q >= IDX_HUNDREDS) ? IDX_UNITS : idx_q + 2'd1;
        end
        state_d = (cnt_d >= CNT_ON) ? ST_ON : ST_BLANK;
    end

    // Display only changes at the frame boundary; a load on that same cycle
    // lands in the shadow and waits for the following frame.
    always_comb begin
        shadow_u_d = shadow_u_q;
        shadow_t_d = shadow_t_q;
        shadow_h_d = shadow_h_q;
        disp_u_d   = disp_u_q;
        disp_t_d   = disp_t_q;
        disp_h_d   = disp_h_q;
        pending_d  = pending_q && !boundary;
        if (boundary && pending_q) begin
            disp_u_d = shadow_u_q;
            disp_t_d = shadow_t_q;
            disp_h_d = shadow_h_q;
        end
        if (load) begin
            shadow_u_d = units;
            shadow_t_d = tens;
            shadow_h_d = hundreds;
            pending_d  = 1'b1;
        end
    end

    // Digit select with leading-zero suppression; a dash digit is never zero.
    always_comb begin
        dec_digit = disp_u_q;
        dec_blank = 1'b0;
        case (idx_q)
            IDX_UNITS: begin
                dec_digit = disp_u_q;
                dec_blank = 1'b0;
            end
            IDX_TENS: begin
                dec_digit = disp_t_q;
                dec_blank = LZ_BLANK && (disp_h_q == 2'd0) && (disp_t_q == 4'd0);
            end
            default: begin
                dec_digit = (disp_h_q == 2'd3) ? DIGIT_DASH : {2'b00, disp_h_q};
                dec_blank = LZ_BLANK && (disp_h_q == 2'd0);
            end
        endcase
        if (state_q == ST_BLANK) begin
            dec_blank = 1'b1;
        end
    end

    seg7_decode u_decode (
        .digit (dec_digit),
        .blank (dec_blank),
        .glyph (glyph)
    );

    // Polarity is applied here only; everything upstream is active-high.
    always_comb begin
        an_onehot = (state_q == ST_ON) ? (3'b001 << idx_q) : 3'b000;
        an_d      = AN_ACTIVE_LOW ? ~an_onehot : an_onehot;
        seg_d     = SEG_ACTIVE_LOW ? ~glyph : glyph;
        dp_d      = DP_RST;
        tick_d    = boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            idx_q      <= IDX_UNITS;
            state_q    <= ST_BLANK;
            shadow_u_q <= '0;
            shadow_t_q <= '0;
            shadow_h_q <= '0;
            pending_q  <= 1'b0;
            disp_u_q   <= '0;
            disp_t_q   <= '0;
            disp_h_q   <= '0;
            seg_q      <= SEG_RST;
            an_q       <= AN_RST;
            dp_q       <= DP_RST;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            state_q    <= state_d;
            shadow_u_q <= shadow_u_d;
            shadow_t_q <= shadow_t_d;
            shadow_h_q <= shadow_h_d;
            pending_q  <= pending_d;
            disp_u_q   <= disp_u_d;
            disp_t_q   <= disp_t_d;
            disp_h_q   <= disp_h_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            dp_q       <= dp_d;
            tick_q     <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign dp         = dp_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan: two instances (leading-zero suppression on and off) share
// stimulus; a frame-position reference model queues expected outputs per clock.
module tb_bcd_display_scan;

    localparam int SLOT  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 3 * SLOT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [3:0] units = 4'd0;
    logic [3:0] tens = 4'd0;
    logic [1:0] hundreds = 2'd0;

    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic [2:0] an_a, an_b;
    logic       tick_a, tick_b;

    bcd_display_scan #(
        .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .units(units), .tens(tens),
        .hundreds(hundreds), .seg(seg_a), .dp(dp_a), .an(an_a), .frame_tick(tick_a)
    );

    bcd_display_scan #(
        .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b0)
    ) dut_nlz (
        .clk(clk), .rst_n(rst_n), .load(load), .units(units), .tens(tens),
        .hundreds(hundreds), .seg(seg_b), .dp(dp_b), .an(an_b), .frame_tick(tick_b)
    );

    always #5 clk = ~clk;

    // Expected entry: {an[2:0], seg_lz[6:0], seg_nolz[6:0], tick}
    logic [17:0] exp_q[$];
    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    // Reference model: frame position plus the digit values per display rules.
    int m_pos = 0;
    int m_disp_u = 0, m_disp_t = 0, m_disp_h = 0;
    int m_shad_u = 0, m_shad_t = 0, m_shad_h = 0;
    bit m_pending = 1'b0;

    logic [6:0] glyph_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                   7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic logic [6:0] ref_glyph(int value, bit dash, bit blank);
        if (dash) return 7'h40;
        if (blank) return 7'h00;
        return glyph_tab[value];
    endfunction

    function automatic logic [6:0] ref_lit(int slot, bit lz);
        if (slot == 0) return ref_glyph(m_disp_u, m_disp_u > 9, 1'b0);
        if (slot == 1) return ref_glyph(m_disp_t, m_disp_t > 9, lz && m_disp_h == 0 && m_disp_t == 0);
        return ref_glyph(m_disp_h, m_disp_h == 3, lz && m_disp_h == 0);
    endfunction

    task automatic check_reset_now();
        compared++;
        if ({an_a, seg_a, dp_a, tick_a, an_b, seg_b, dp_b, tick_b} !==
            {3'b111, 7'h7F, 1'b1, 1'b0, 3'b111, 7'h7F, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL async_reset: an=%b/%b seg=%h/%h dp=%b/%b tick=%b/%b, required an=111 seg=7f dp=1 tick=0",
                     an_a, an_b, seg_a, seg_b, dp_a, dp_b, tick_a, tick_b);
        end
    endtask

    task automatic step(bit rst_val, bit ld, int u, int t, int h);
        logic [2:0] oh;
        int slot, phase;
        @(negedge clk);
        if (!rst_val && rst_n) begin
            rst_n = 1'b0;
            #1;
            check_reset_now();
        end
        rst_n    = rst_val;
        load     = ld;
        units    = u[3:0];
        tens     = t[3:0];
        hundreds = h[1:0];
        if (!rst_val) begin
            exp_q.push_back({3'b111, 7'h7F, 7'h7F, 1'b0});
            m_pos = 0;
            m_disp_u = 0; m_disp_t = 0; m_disp_h = 0;
            m_shad_u = 0; m_shad_t = 0; m_shad_h = 0;
            m_pending = 1'b0;
        end else begin
            slot  = m_pos / SLOT;
            phase = m_pos % SLOT;
            if (phase < BLANK) begin
                exp_q.push_back({3'b111, 7'h7F, 7'h7F, m_pos == FRAME - 1});
            end else begin
                oh = 3'b001 << slot;
                exp_q.push_back({~oh, ~ref_lit(slot, 1'b1), ~ref_lit(slot, 1'b0), m_pos == FRAME - 1});
            end
            if (m_pos == FRAME - 1 && m_pending) begin
                m_disp_u = m_shad_u; m_disp_t = m_shad_t; m_disp_h = m_shad_h;
                m_pending = 1'b0;
            end
            if (ld) begin
                m_shad_u = u; m_shad_t = t; m_shad_h = h;
                m_pending = 1'b1;
            end
            m_pos = (m_pos + 1) % FRAME;
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'b0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
    endtask

    task automatic wait_pos(int target);
        for (int k = 0; k < FRAME && m_pos != target; k++) idle(1);
    endtask

    task automatic load_at(int target, int u, int t, int h);
        wait_pos(target);
        step(1'b1, 1'b1, u, t, h);
    endtask

    task automatic hold_reset(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0);
    endtask

    // Monitor: one scoreboard entry is retired per active edge.
    initial begin
        logic [17:0] e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                compared++;
                if ({an_a, seg_a, dp_a, tick_a} !== {e[17:15], e[14:8], 1'b1, e[0]}) begin
                    mismatched++;
                    $display("FAIL scan_lz cycle %0d: an=%b seg=%h dp=%b tick=%b, required an=%b seg=%h dp=1 tick=%b",
                             cyc, an_a, seg_a, dp_a, tick_a, e[17:15], e[14:8], e[0]);
                end
                compared++;
                if ({an_b, seg_b, dp_b, tick_b} !== {e[17:15], e[7:1], 1'b1, e[0]}) begin
                    mismatched++;
                    $display("FAIL scan_nolz cycle %0d: an=%b seg=%h dp=%b tick=%b, required an=%b seg=%h dp=1 tick=%b",
                             cyc, an_b, seg_b, dp_b, tick_b, e[17:15], e[7:1], e[0]);
                end
                compared++;
                if ($countones(~an_a) > 1 || $countones(~an_b) > 1) begin
                    mismatched++;
                    $display("FAIL anode_overlap cycle %0d: an=%b/%b, required at most one low", cyc, an_a, an_b);
                end
            end
        end
    end

    initial begin
        int u_t [5] = '{5, 7, 0, 0, 12};
        int t_t [5] = '{5, 0, 0, 7, 0};
        int h_t [5] = '{2, 0, 0, 0, 3};

        hold_reset(3);
        idle(2 * FRAME + 5);

        // Reset mid-scan while an anode is lit, with a load still pending.
        load_at(5, 9, 9, 1);
        wait_pos(13);
        hold_reset(4);
        idle(2 * FRAME + 3);

        for (int i = 0; i < 5; i++) begin
            load_at($urandom_range(0, FRAME - 1), u_t[i], t_t[i], h_t[i]);
            idle(2 * FRAME + $urandom_range(0, 7));
        end

        // Load on the boundary cycle, then again mid-frame.
        load_at(FRAME - 1, 3, 2, 1);
        load_at(12, 9, 0, 2);
        idle(3 * FRAME);

        // Two loads inside one frame: only the second may ever appear.
        load_at(4, 1, 1, 1);
        load_at(9, 8, 4, 2);
        idle(2 * FRAME);

        // Back-to-back loads across the boundary.
        load_at(FRAME - 2, 6, 6, 0);
        step(1'b1, 1'b1, 2, 0, 0);
        step(1'b1, 1'b1, 4, 3, 0);
        idle(2 * FRAME);

        for (int i = 0; i < 25; i++) begin
            idle($urandom_range(0, 40));
            step(1'b1, 1'b1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
        end
        idle(2 * FRAME);

        @(posedge clk);
        #2;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
